ttt_network_queued: RTL and testbench

Parametrised successor to the token network stage. Accepts spike events `(source_id, token_startstop)` from the processor array into an input queue. Scans a runtime-programmable connection table and emits one signed good/bad token update per matching connection to the processor array. Adds a valid/ready handshake on both sides, an input FIFO, and table programming, so upstream and downstream can both stall without losing events.

---
 rtl/ttt_network_pkg.sv | 39 +++
 rtl/ttt_event_fifo.sv | 48 ++++
 rtl/ttt_network_queued.sv | 136 +++++++++++++
 tb/tb_ttt_network_queued.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_network_pkg.sv
// Shared types for the queued token network: FSM states, queued event and
// connection-table entry layouts, and the saturating negate used for stop events.
package ttt_network_pkg;

  // Widest source/target id and token weight any instance may use.
  localparam int MAX_ID_W  = 8;
  localparam int MAX_TOK_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT
  } state_t;

  typedef logic signed [MAX_TOK_W-1:0] tok_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] source;
    logic [1:0]          startstop;
  } event_t;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] source;
    logic [MAX_ID_W-1:0] target;
    tok_t                good;
    tok_t                bad;
  } conn_t;

  // Negate an n-bit signed value held sign-extended in a tok_t; the most
  // negative n-bit value maps to the most positive one instead of wrapping.
  function automatic tok_t sat_neg(input tok_t v, input int n);
    tok_t min_v;
    min_v = '1 << (n - 1);
    if (v == min_v) sat_neg = ~min_v;
    else            sat_neg = -v;
  endfunction

endpackage

// File: rtl/ttt_event_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two so
// the read/write pointers can wrap naturally.
module ttt_event_fifo #(
  parameter  int WIDTH = 10,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push  = push && (count != CNT_W'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ttt_network_queued.sv
// Queued token network: buffers spike events and scans a programmable connection
// table, emitting one signed token update per match. Define TTT_NETWORK_SKIP_ZERO_EN
// to suppress updates from matching entries whose good and bad weights are both 0.
module ttt_network_queued
  import ttt_network_pkg::*;
#(
  parameter  int NUM_PROCESSORS  = 10,
  parameter  int NUM_CONNECTIONS = 50,
  parameter  int NEW_TOKENS_BITS = 4,
  parameter  int FIFO_DEPTH      = 4,
  localparam int ID_W            = $clog2(NUM_PROCESSORS),
  localparam int CONN_W          = $clog2(NUM_CONNECTIONS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_in,
  output logic                              ready_in,
  input  logic [ID_W-1:0]                   source_id,
  input  logic [1:0]                        token_startstop,
  output logic                              valid_out,
  input  logic                              ready_out,
  output logic [ID_W-1:0]                   target_id,
  output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                              done,
  output logic                              busy,
  input  logic                              prog_en,
  input  logic [CONN_W-1:0]                 prog_addr,
  input  logic                              prog_valid,
  input  logic [ID_W-1:0]                   prog_source,
  input  logic [ID_W-1:0]                   prog_target,
  input  logic signed [NEW_TOKENS_BITS-1:0] prog_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] prog_bad
);

  localparam int                EV_W     = $bits(event_t);
  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CONN_W-1:0] LAST_IDX = CONN_W'(NUM_CONNECTIONS - 1);

  state_t            state;
  logic [CONN_W-1:0] idx, scan_idx;
  conn_t             tbl [NUM_CONNECTIONS];
  conn_t             entry;
  event_t            push_ev, head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty, pop, scanning, hit, last, net_zero, is_stop;
  tok_t              good_d, bad_d;

  assign push_ev  = event_t'{source: MAX_ID_W'(source_id), startstop: token_startstop};
  assign ready_in = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  ttt_event_fifo #(.WIDTH(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (valid_in && ready_in),
    .push_data (push_ev),
    .pop       (pop),
    .pop_data  (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // The IDLE cycle that picks up a new head event already examines index 0,
  // so the head is read straight from the FIFO until the event is popped.
  always_comb begin
    scan_idx = (state == ST_IDLE) ? '0 : idx;
    entry    = tbl[scan_idx];
    net_zero = (head.startstop[1] == head.startstop[0]);
    is_stop  = (head.startstop == 2'b01);
    hit      = entry.valid && (entry.source == head.source);
`ifdef TTT_NETWORK_SKIP_ZERO_EN
    hit      = hit && ((entry.good != '0) || (entry.bad != '0));
`endif
    last     = (scan_idx == LAST_IDX);
    scanning = (state == ST_SCAN) || ((state == ST_IDLE) && !fifo_empty && !net_zero);
    good_d   = is_stop ? sat_neg(entry.good, NEW_TOKENS_BITS) : entry.good;
    bad_d    = is_stop ? sat_neg(entry.bad, NEW_TOKENS_BITS) : entry.bad;
    pop      = ((state == ST_IDLE) && !fifo_empty && net_zero)
            || (scanning && !hit && last)
            || ((state == ST_EMIT) && ready_out && (idx == LAST_IDX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      idx             <= '0;
      valid_out       <= 1'b0;
      target_id       <= '0;
      new_good_tokens <= '0;
      new_bad_tokens  <= '0;
      done            <= 1'b0;
    end else begin
      done <= pop;
      if (scanning) begin
        if (hit) begin
          valid_out       <= 1'b1;
          target_id       <= entry.target[ID_W-1:0];
          new_good_tokens <= good_d[NEW_TOKENS_BITS-1:0];
          new_bad_tokens  <= bad_d[NEW_TOKENS_BITS-1:0];
          idx             <= scan_idx;
          state           <= ST_EMIT;
        end else if (last) begin
          state <= ST_IDLE;
        end else begin
          idx   <= scan_idx + 1'b1;
          state <= ST_SCAN;
        end
      end else if ((state == ST_EMIT) && ready_out) begin
        valid_out <= 1'b0;
        if (idx == LAST_IDX) begin
          state <= ST_IDLE;
        end else begin
          idx   <= idx + 1'b1;
          state <= ST_SCAN;
        end
      end
    end
  end

  // Table writes are only honoured between events so a scan never sees a
  // half-updated table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CONNECTIONS; i++) tbl[i] <= '0;
    end else if (prog_en && (state == ST_IDLE) &&
                 ({1'b0, prog_addr} < (CONN_W + 1)'(NUM_CONNECTIONS))) begin
      tbl[prog_addr] <= conn_t'{valid:  prog_valid,
                                source: MAX_ID_W'(prog_source),
                                target: MAX_ID_W'(prog_target),
                                good:   tok_t'(prog_good),
                                bad:    tok_t'(prog_bad)};
    end
  end

endmodule

// File: tb/tb_ttt_network_queued.sv
// Self-checking bench for ttt_network_queued: a table/queue model predicts every
// update from accepted events, plus directed timing and boundary checks.
module tb_ttt_network_queued;

  localparam int NP = 10;
  localparam int NC = 50;
  localparam int NB = 4;
  localparam int FD = 4;
  localparam int IW = $clog2(NP);
  localparam int CW = $clog2(NC);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 valid_in, ready_in, valid_out, ready_out, done, busy;
  logic [IW-1:0]        source_id, target_id, prog_source, prog_target;
  logic [1:0]           token_startstop;
  logic signed [NB-1:0] new_good_tokens, new_bad_tokens, prog_good, prog_bad;
  logic                 prog_en, prog_valid;
  logic [CW-1:0]        prog_addr;

  always #5 clk = ~clk;

  ttt_network_queued #(
    .NUM_PROCESSORS(NP), .NUM_CONNECTIONS(NC), .NEW_TOKENS_BITS(NB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .source_id(source_id), .token_startstop(token_startstop),
    .valid_out(valid_out), .ready_out(ready_out), .target_id(target_id),
    .new_good_tokens(new_good_tokens), .new_bad_tokens(new_bad_tokens),
    .done(done), .busy(busy), .prog_en(prog_en), .prog_addr(prog_addr),
    .prog_valid(prog_valid), .prog_source(prog_source), .prog_target(prog_target),
    .prog_good(prog_good), .prog_bad(prog_bad)
  );

  typedef struct {
    int tgt;
    int good;
    int bad;
  } upd_t;

  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;
  upd_t exp_q[$];
  upd_t u;
  int   m_valid[NC], m_src[NC], m_tgt[NC], m_good[NC], m_bad[NC];
  logic                 hold_prev = 1'b0;
  logic [IW-1:0]        prev_tgt;
  logic signed [NB-1:0] prev_good, prev_bad;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int clamp(input int v);
    int hi, lo;
    hi = (1 << (NB - 1)) - 1;
    lo = -(1 << (NB - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Updates an accepted event must produce, in table order.
  function automatic void model_event(input int src, input logic [1:0] ss);
    upd_t e;
    if (ss != 2'b10 && ss != 2'b01) return;
    for (int i = 0; i < NC; i++) begin
      if (m_valid[i] != 0 && m_src[i] == src) begin
`ifdef TTT_NETWORK_SKIP_ZERO_EN
        if (m_good[i] == 0 && m_bad[i] == 0) continue;
`endif
        e.tgt  = m_tgt[i];
        e.good = (ss == 2'b01) ? clamp(-m_good[i]) : m_good[i];
        e.bad  = (ss == 2'b01) ? clamp(-m_bad[i]) : m_bad[i];
        exp_q.push_back(e);
      end
    end
  endfunction

  // Compare process: checks every handshake against the model and output stability.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev)
        checkOutput("hold_stable",
          int'({valid_out, target_id, new_good_tokens, new_bad_tokens} ==
               {1'b1, prev_tgt, prev_good, prev_bad}), 1);
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_update", int'(valid_out), 0);
        end else begin
          u = exp_q.pop_front();
          checkOutput("upd_target", int'(target_id), u.tgt);
          checkOutput("upd_good", int'(new_good_tokens), u.good);
          checkOutput("upd_bad", int'(new_bad_tokens), u.bad);
        end
      end
      hold_prev = valid_out && !ready_out;
      prev_tgt  = target_id;
      prev_good = new_good_tokens;
      prev_bad  = new_bad_tokens;
      if (valid_in && ready_in) model_event(int'(source_id), token_startstop);
      if (done) done_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int src, input logic [1:0] ss);
    logic acc;
    int   waited;
    waited          = 0;
    acc             = 1'b0;
    source_id       = IW'(src);
    token_startstop = ss;
    valid_in        = 1'b1;
    while (!acc && waited < 1000) begin
      acc = ready_in;
      step();
      waited++;
    end
    if (!acc) checkOutput("accept_timeout", waited, 0);
    valid_in = 1'b0;
  endtask

  task automatic programEntry(input int addr, input int v, input int src, input int tgt,
                              input int g, input int b);
    prog_en     = 1'b1;
    prog_addr   = CW'(addr);
    prog_valid  = (v != 0);
    prog_source = IW'(src);
    prog_target = IW'(tgt);
    prog_good   = NB'(g);
    prog_bad    = NB'(b);
    step();
    prog_en = 1'b0;
    if (addr < NC) begin
      m_valid[addr] = v;
      m_src[addr]   = src;
      m_tgt[addr]   = tgt;
      m_good[addr]  = g;
      m_bad[addr]   = b;
    end
  endtask

  // Cycle numbers are relative to the accept cycle t (t+1 is the first after it).
  task automatic runEvent(input int src, input logic [1:0] ss, input int limit,
                          output int done_cyc, output int first_vo,
                          output int f_tgt, output int f_good, output int f_bad);
    int cyc;
    applyStimulus(src, ss);
    cyc = 1; done_cyc = 0; first_vo = 0; f_tgt = -1; f_good = -99; f_bad = -99;
    while (done_cyc == 0 && cyc <= limit) begin
      if (valid_out && first_vo == 0) begin
        first_vo = cyc;
        f_tgt    = int'(target_id);
        f_good   = int'(new_good_tokens);
        f_bad    = int'(new_bad_tokens);
      end
      if (done) done_cyc = cyc;
      else begin
        step();
        cyc++;
      end
    end
  endtask

  task automatic waitValid(input int limit, output int cyc);
    cyc = 1;
    while (!valid_out && cyc < limit) begin
      step();
      cyc++;
    end
  endtask

  task automatic stallHandshake(input int n);
    repeat (n) step();
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
  endtask

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog: time %0t, required finish before 200000", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc, fv, ft, fg, fb, c, d0;
    for (int i = 0; i < NC; i++) m_valid[i] = 0;
    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b0; source_id = '0; token_startstop = '0;
    prog_en = 1'b0; prog_addr = '0; prog_valid = 1'b0; prog_source = '0; prog_target = '0;
    prog_good = '0; prog_bad = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkOutput("rst_valid_out", int'(valid_out), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_ready_in", int'(ready_in), 1);
    checkOutput("rst_target", int'(target_id), 0);

    // Single start event through entry 3.
    programEntry(3, 1, 2, 5, 3, -1);
    ready_out = 1'b1;
    runEvent(2, 2'b10, 200, dc, fv, ft, fg, fb);
    checkOutput("t1_first_valid_cycle", fv, 5);
    checkOutput("t1_target", ft, 5);
    checkOutput("t1_good", fg, 3);
    checkOutput("t1_bad", fb, -1);
    checkOutput("t1_done_cycle", dc, 52);
    checkOutput("t1_busy_after", int'(busy), 0);

    // Stop event with the most negative weight saturates.
    programEntry(3, 1, 2, 5, -8, -1);
    runEvent(2, 2'b01, 200, dc, fv, ft, fg, fb);
    checkOutput("t2_good_sat", fg, 7);
    checkOutput("t2_bad", fb, 1);
    checkOutput("t2_done_cycle", dc, 52);

    // Net-zero event: no scan, done two cycles after accept.
    runEvent(2, 2'b11, 20, dc, fv, ft, fg, fb);
    checkOutput("t3_done_cycle", dc, 2);
    checkOutput("t3_no_valid", fv, 0);

    // Out-of-range program address is dropped; event with no match.
    programEntry(55, 1, 7, 1, 1, 1);
    runEvent(7, 2'b10, 200, dc, fv, ft, fg, fb);
    checkOutput("t3b_done_cycle", dc, 51);
    checkOutput("t3b_no_valid", fv, 0);

    // Zero-weight matching entry.
    programEntry(20, 1, 8, 3, 0, 0);
    runEvent(8, 2'b10, 200, dc, fv, ft, fg, fb);
`ifdef TTT_NETWORK_SKIP_ZERO_EN
    checkOutput("tz_no_valid", fv, 0);
    checkOutput("tz_done_cycle", dc, 51);
`else
    checkOutput("tz_first_valid_cycle", fv, 22);
    checkOutput("tz_good", fg, 0);
    checkOutput("tz_done_cycle", dc, 52);
`endif

    // Fill the queue while downstream stalls.
    programEntry(3, 1, 2, 5, 3, -1);
    programEntry(10, 1, 4, 1, 2, 2);
    ready_out = 1'b0;
    d0 = done_count;
    applyStimulus(2, 2'b10);
    applyStimulus(4, 2'b01);
    applyStimulus(2, 2'b01);
    applyStimulus(4, 2'b10);
    checkOutput("t4_ready_low_after_4", int'(ready_in), 0);
    source_id = IW'(2); token_startstop = 2'b10; valid_in = 1'b1;
    repeat (3) step();
    checkOutput("t4_fifth_held", int'(ready_in), 0);
    ready_out = 1'b1;
    applyStimulus(2, 2'b10);
    c = 0;
    while (busy && c < 2000) begin
      step();
      c++;
    end
    step();
    checkOutput("t4_idle", int'(busy), 0);
    checkOutput("t4_queue_drained", exp_q.size(), 0);
    checkOutput("t4_done_count", done_count - d0, 5);

    // First and last entries both match, each stalled three cycles.
    programEntry(0, 1, 6, 2, 1, 0);
    programEntry(49, 1, 6, 9, -3, 4);
    ready_out = 1'b0;
    d0 = done_count;
    applyStimulus(6, 2'b10);
    waitValid(100, c);
    checkOutput("t5_first_valid_cycle", c, 2);
    checkOutput("t5_first_target", int'(target_id), 2);
    checkOutput("t5_first_good", int'(new_good_tokens), 1);
    stallHandshake(3);
    checkOutput("t5_no_early_done", int'(done), 0);
    waitValid(100, c);
    checkOutput("t5_second_target", int'(target_id), 9);
    checkOutput("t5_second_good", int'(new_good_tokens), -3);
    checkOutput("t5_second_bad", int'(new_bad_tokens), 4);
    stallHandshake(3);
    checkOutput("t5_done_after_handshake", int'(done), 1);
    checkOutput("t5_busy_after", int'(busy), 0);
    step();
    checkOutput("t5_done_pulse_count", done_count - d0, 1);

    // Reset while an update is held in EMIT.
    programEntry(5, 1, 3, 4, 1, 1);
    applyStimulus(3, 2'b10);
    waitValid(100, c);
    checkOutput("t6_valid_cycle", c, 7);
    #2 reset = 1'b1;
    #1;
    checkOutput("t6_rst_valid_out", int'(valid_out), 0);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_ready_in", int'(ready_in), 1);
    for (int i = 0; i < NC; i++) m_valid[i] = 0;
    step();
    reset = 1'b0;
    ready_out = 1'b1;
    runEvent(3, 2'b10, 200, dc, fv, ft, fg, fb);
    checkOutput("t6_table_cleared", fv, 0);
    checkOutput("t6_done_cycle", dc, 51);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
